// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller:
// FSM states, scoreboard entry layout and the register-match helper.
package pipe_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  localparam int         SB_W     = 7;
  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic       valid;
    logic       we;
    logic [4:0] wreg;
  } sb_t;

  // $0 is hardwired, so it never creates a dependency
  function automatic logic hit(sb_t e, logic [4:0] r);
    return e.valid && e.we && (e.wreg == r) && (r != REG_ZERO);
  endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Shadow of the EX/MEM/WB destination registers plus the RAW compare
// against the source registers of the instruction sitting in ID.
module hazard_scoreboard
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int WB_BYPASS = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            advance,
  input  logic            squash_young,
  input  logic [SB_W-1:0] push,
  input  logic            id_valid,
  input  logic [4:0]      rs,
  input  logic [4:0]      rt,
  input  logic            uses_rs,
  input  logic            uses_rt,
  output logic            raw,
  output logic            empty
);

  sb_t  sb_ex;
  sb_t  sb_mem;
  sb_t  sb_wb;
  logic wb_on;
  logic m_rs;
  logic m_rt;

  assign wb_on = (WB_BYPASS == 0);

  assign m_rs = hit(sb_ex, rs) | hit(sb_mem, rs)
              | (wb_on & hit(sb_wb, rs));
  assign m_rt = hit(sb_ex, rt) | hit(sb_mem, rt)
              | (wb_on & hit(sb_wb, rt));

  assign raw   = id_valid & ((uses_rs & m_rs) | (uses_rt & m_rt));
  assign empty = !(sb_ex.valid | sb_mem.valid | sb_wb.valid);

  // a bubble enters EX whenever ID does not advance
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sb_ex  <= '0;
      sb_mem <= '0;
      sb_wb  <= '0;
    end else begin
      sb_ex  <= advance ? sb_t'(push) : '0;
      sb_mem <= squash_young ? '0 : sb_ex;
      sb_wb  <= sb_mem;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: RAW stall, taken-branch squash, drain/halt FSM
// and saturating stall/flush counters for the 5-stage pipeline.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int WB_BYPASS = 0,
  parameter int CNT_W     = 16
) (
  input  logic             clk_i,
  input  logic             rst_n,
  input  logic [4:0]       id_rs_i,
  input  logic [4:0]       id_rt_i,
  input  logic             id_uses_rs_i,
  input  logic             id_uses_rt_i,
  input  logic             id_regwrite_i,
  input  logic [4:0]       id_wreg_i,
  input  logic             branch_taken_i,
  input  logic             halt_req_i,
  output logic             pc_write_o,
  output logic             ifid_write_o,
  output logic             ifid_flush_o,
  output logic             idex_bubble_o,
  output logic             exmem_flush_o,
  output logic             halted_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  state_t state;
  logic   id_valid;
  logic   raw;
  logic   sb_empty;
  logic   do_br;
  logic   do_stall;
  logic   do_hold;
  logic   do_drain;
  logic   advance;

  hazard_scoreboard #(
    .WB_BYPASS (WB_BYPASS)
  ) u_sb (
    .clk          (clk_i),
    .rst_n        (rst_n),
    .advance      (advance),
    .squash_young (do_br),
    .push         ({id_valid, id_regwrite_i, id_wreg_i}),
    .id_valid     (id_valid),
    .rs           (id_rs_i),
    .rt           (id_rt_i),
    .uses_rs      (id_uses_rs_i),
    .uses_rt      (id_uses_rt_i),
    .raw          (raw),
    .empty        (sb_empty)
  );

  assign do_br    = branch_taken_i;
  assign do_stall = !do_br && raw;
  assign do_hold  = !do_br && !raw && (state == HALTED);
  assign do_drain = !do_br && !raw && (state == DRAIN);
  assign advance  = !do_br && !raw && (state != HALTED);
  assign halted_o = (state == HALTED);

  always_comb begin
    pc_write_o    = 1'b0;
    ifid_write_o  = 1'b0;
    ifid_flush_o  = 1'b0;
    idex_bubble_o = 1'b0;
    exmem_flush_o = 1'b0;
    unique case (1'b1)
      do_br: begin
        pc_write_o    = 1'b1;
        ifid_write_o  = 1'b1;
        ifid_flush_o  = 1'b1;
        idex_bubble_o = 1'b1;
        exmem_flush_o = 1'b1;
      end
      do_stall: idex_bubble_o = 1'b1;
      do_hold:  idex_bubble_o = 1'b1;
      // PC frozen; the ID instruction issues and IF/ID empties
      do_drain: begin
        ifid_write_o = 1'b1;
        ifid_flush_o = 1'b1;
      end
      default: begin
        pc_write_o   = 1'b1;
        ifid_write_o = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      state       <= RUN;
      id_valid    <= 1'b0;
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      if (do_br)
        id_valid <= 1'b0;
      else if (advance)
        id_valid <= (state == RUN);

      if (do_stall && stall_cnt_o != '1)
        stall_cnt_o <= stall_cnt_o + CNT_W'(1);
      if (do_br && flush_cnt_o != '1)
        flush_cnt_o <= flush_cnt_o + CNT_W'(1);

      unique case (state)
        RUN:
          if (halt_req_i) state <= DRAIN;
        DRAIN:
          if (!halt_req_i)
            state <= RUN;
          else if (!id_valid && sb_empty)
            state <= HALTED;
        HALTED:
          if (!halt_req_i) state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: three instances (WB compared, WB bypassed,
// 4-bit counters) checked every cycle against an in-flight register model.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] rs = '0, rt = '0, wreg = '0;
  logic       urs = 1'b0, urt = 1'b0, rw = 1'b0;
  logic       br = 1'b0, halt = 1'b0;

  always #5 clk = ~clk;

  // {pc_write, ifid_write, ifid_flush, idex_bubble, exmem_flush, halted}
  logic [5:0] ctl_a [3];
  int         sc_a  [3];
  int         fc_a  [3];

  for (genvar k = 0; k < 3; k++) begin : g_dut
    localparam int CW = (k == 2) ? 4 : 16;
    logic [CW-1:0] s, f;
    logic p, w, fl, b, e, h;
    pipe_hazard_ctrl #(
      .WB_BYPASS ((k == 1) ? 1 : 0),
      .CNT_W     (CW)
    ) dut (
      .clk_i          (clk),
      .rst_n          (rst_n),
      .id_rs_i        (rs),
      .id_rt_i        (rt),
      .id_uses_rs_i   (urs),
      .id_uses_rt_i   (urt),
      .id_regwrite_i  (rw),
      .id_wreg_i      (wreg),
      .branch_taken_i (br),
      .halt_req_i     (halt),
      .pc_write_o     (p),
      .ifid_write_o   (w),
      .ifid_flush_o   (fl),
      .idex_bubble_o  (b),
      .exmem_flush_o  (e),
      .halted_o       (h),
      .stall_cnt_o    (s),
      .flush_cnt_o    (f)
    );
    assign ctl_a[k] = {p, w, fl, b, e, h};
    assign sc_a[k]  = int'(s);
    assign fc_a[k]  = int'(f);
  end

  // model: mode 0=run 1=drain 2=halted; stage 0=EX 1=MEM 2=WB
  // m_d holds the register an in-flight instruction will write (0 = none)
  int m_mode [3];
  int m_idv  [3];
  int m_stc  [3];
  int m_flc  [3];
  int m_v    [3][3];
  int m_d    [3][3];

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  function automatic bit hz(int k, int r);
    if (r == 0) return 1'b0;
    for (int i = 0; i < 3; i++)
      if (!(k == 1 && i == 2) && m_v[k][i] != 0 && m_d[k][i] == r)
        return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_raw(int k);
    return m_idv[k] != 0 &&
      ((urs && hz(k, int'(rs))) || (urt && hz(k, int'(rt))));
  endfunction

  function automatic logic [5:0] m_ctl(int k);
    bit h;
    h = (m_mode[k] == 2);
    if (br)             return {5'b11111, h};
    if (m_raw(k))       return {5'b00010, h};
    if (h)              return 6'b000101;
    if (m_mode[k] == 1) return 6'b011000;
    return 6'b110000;
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      bit r, emp;
      int cmax;
      cmax = (k == 2) ? 15 : 65535;
      if (!rst_n) begin
        m_mode[k] = 0; m_idv[k] = 0; m_stc[k] = 0; m_flc[k] = 0;
        for (int i = 0; i < 3; i++) begin
          m_v[k][i] = 0; m_d[k][i] = 0;
        end
      end else begin
        r   = m_raw(k);
        emp = m_idv[k] == 0 && m_v[k][0] == 0 &&
              m_v[k][1] == 0 && m_v[k][2] == 0;
        if (br) begin
          m_v[k][2] = m_v[k][1]; m_d[k][2] = m_d[k][1];
          m_v[k][1] = 0; m_d[k][1] = 0;
          m_v[k][0] = 0; m_d[k][0] = 0;
          m_idv[k] = 0;
          if (m_flc[k] < cmax) m_flc[k]++;
        end else begin
          m_v[k][2] = m_v[k][1]; m_d[k][2] = m_d[k][1];
          m_v[k][1] = m_v[k][0]; m_d[k][1] = m_d[k][0];
          if (!r && m_mode[k] != 2) begin
            m_v[k][0] = m_idv[k];
            m_d[k][0] = (m_idv[k] != 0 && rw) ? int'(wreg) : 0;
            m_idv[k] = (m_mode[k] == 0) ? 1 : 0;
          end else begin
            m_v[k][0] = 0; m_d[k][0] = 0;
          end
          if (r && m_stc[k] < cmax) m_stc[k]++;
        end
        case (m_mode[k])
          0: if (halt) m_mode[k] = 1;
          1: if (!halt) m_mode[k] = 0; else if (emp) m_mode[k] = 2;
          default: if (!halt) m_mode[k] = 0;
        endcase
      end
    end
  end

  task automatic cmp_all();
    for (int k = 0; k < 3; k++) begin
      logic [5:0] e;
      e = m_ctl(k);
      n_cmp++;
      if (ctl_a[k] !== e) begin
        n_bad++;
        $display("FAIL ctl dut%0d @%0t: got %b want %b", k, $time, ctl_a[k], e);
      end
      n_cmp++;
      if (sc_a[k] != m_stc[k]) begin
        n_bad++;
        $display("FAIL stall_cnt dut%0d @%0t: got %0d want %0d", k, $time, sc_a[k], m_stc[k]);
      end
      n_cmp++;
      if (fc_a[k] != m_flc[k]) begin
        n_bad++;
        $display("FAIL flush_cnt dut%0d @%0t: got %0d want %0d", k, $time, fc_a[k], m_flc[k]);
      end
    end
  endtask

  task automatic chk(input string nm, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0d want %0d", nm, $time, got, want);
    end
  endtask

  // one cycle per count: drive the ID instruction, then check
  task automatic put(input bit w, input int wr, input bit u1, input int r1,
                     input bit u2, input int r2, input bit b, input int n);
    repeat (n) begin
      @(negedge clk);
      rw = w; wreg = 5'(wr); urs = u1; rs = 5'(r1);
      urt = u2; rt = 5'(r2); br = b;
      #2;
      cmp_all();
    end
  endtask

  task automatic nop(input int n);
    put(0, 0, 0, 0, 0, 0, 0, n);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; br = 1'b0;
    #2;
    if (chk_en) cmp_all();
    @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1'b1;
    #2;
    cmp_all();
  endtask

  task automatic wait_halt(input string nm);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      nop(1);
      if (ctl_a[0][0]) done = 1'b1;
    end
    chk(nm, int'(done), 1);
  endtask

  initial begin
    do_reset();
    chk("reset_ctl", int'(ctl_a[0]), 48);
    chk("reset_stall_cnt", sc_a[0], 0);
    chk("reset_flush_cnt", fc_a[0], 0);

    // addi $1 then add $2,$1,$1
    nop(1);
    put(1, 1, 1, 0, 0, 0, 0, 1);
    put(1, 2, 1, 1, 1, 1, 0, 4);
    nop(2);
    chk("raw_wb_stall_cnt", sc_a[0], 3);
    chk("raw_bypass_stall_cnt", sc_a[1], 2);

    // write $0 then read $0
    do_reset();
    nop(1);
    put(1, 0, 1, 0, 0, 0, 0, 1);
    put(0, 0, 1, 0, 1, 0, 0, 1);
    chk("r0_pc_write", int'(ctl_a[0][5]), 1);
    nop(3);
    chk("r0_stall_cnt", sc_a[0], 0);

    // branch squashes EX producer of $5; consumer later must not stall
    do_reset();
    nop(1);
    put(1, 5, 1, 0, 0, 0, 0, 1);
    put(0, 0, 0, 0, 0, 0, 1, 1);
    chk("br_ctl", int'(ctl_a[0]), 62);
    put(0, 0, 1, 5, 0, 0, 0, 1);
    chk("br_after_ctl", int'(ctl_a[0]), 48);
    put(0, 0, 1, 5, 0, 0, 0, 2);
    chk("br_flush_cnt", fc_a[0], 1);
    chk("br_squash_stall_cnt", sc_a[0], 0);

    // branch and raw together
    do_reset();
    nop(1);
    put(1, 3, 0, 0, 0, 0, 0, 1);
    put(1, 4, 1, 3, 0, 0, 1, 1);
    chk("br_raw_ctl", int'(ctl_a[0]), 62);
    nop(3);
    chk("br_raw_stall_cnt", sc_a[0], 0);
    chk("br_raw_flush_cnt", fc_a[0], 1);

    // drain with three producers in flight, then release
    do_reset();
    nop(1);
    put(1, 1, 0, 0, 0, 0, 0, 1);
    put(1, 2, 0, 0, 0, 0, 0, 1);
    put(1, 3, 0, 0, 0, 0, 0, 1);
    halt = 1'b1;
    wait_halt("halt_rise");
    nop(2);
    chk("halted_no_fetch", int'(ctl_a[0]), 5);
    halt = 1'b0;
    nop(1);
    put(1, 6, 1, 1, 0, 0, 0, 1);
    chk("resume_pc_write", int'(ctl_a[0]), 48);
    nop(3);

    // reset in the middle of a stall
    do_reset();
    nop(1);
    put(1, 7, 0, 0, 0, 0, 0, 1);
    put(0, 0, 1, 7, 0, 0, 0, 2);
    do_reset();
    chk("rst_stall_ctl", int'(ctl_a[0]), 48);
    chk("rst_stall_cnt", sc_a[0], 0);

    // reset while halted
    nop(1);
    halt = 1'b1;
    wait_halt("halt_rise2");
    halt = 1'b0;
    do_reset();
    chk("rst_halt_ctl", int'(ctl_a[0]), 48);
    nop(2);

    // 21 stall cycles saturate the 4-bit counter
    do_reset();
    nop(1);
    for (int i = 0; i < 7; i++) begin
      put(1, 9, 0, 0, 0, 0, 0, 1);
      put(0, 0, 1, 9, 0, 0, 0, 4);
    end
    nop(2);
    chk("sat_stall_cnt4", sc_a[2], 15);
    chk("sat_stall_cnt16", sc_a[0], 21);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
